fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the fetch unit. It drives the unit's stall/jal/jalr controls, runs a single-outstanding valid/ready handshake to instruction memory using the current PC, and hands fetched instructions to decode with backpressure. It also applies control-flow redirects from execute and discards responses belonging to squashed fetches.

## Interface
- XLEN, 32: address/data width.
- SQ_CNT_W, 16: width of the squashed-response counter.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- io_pc  in  XLEN  current PC from the fetch unit.
- io_imem_req_valid  out  1  fetch request.
- io_imem_req_ready  in  1  memory accepts the request.
- io_imem_req_addr  out  XLEN  request address; always equals io_pc.
- io_imem_resp_valid  in  1  response strobe.
- io_imem_resp_data  in  32  instruction word.
- io_redirect_valid  in  1  redirect request from execute, one cycle.
- io_redirect_is_jalr  in  1  1 selects jalr (rs1+imm), 0 selects jal (pc+imm).
- io_redirect_rs1  in  XLEN  jalr base.
- io_redirect_imm  in  XLEN  offset; for jal it is relative to the current io_pc.
- io_dec_stall  in  1  decode cannot accept this cycle.
- io_stall_en  out  1  to fetch unit: hold PC.
- io_jal_en  out  1  to fetch unit.
- io_jalr_en  out  1  to fetch unit.
- io_imm  out  XLEN  combinational pass-through of io_redirect_imm.
- io_rs1  out  XLEN  combinational pass-through of io_redirect_rs1.
- io_inst_valid  out  1  instruction valid to decode.
- io_inst  out  32  instruction word.
- io_inst_pc  out  XLEN  PC of io_inst.
- io_squash_count  out  SQ_CNT_W  saturating count of discarded responses.

## Operation
- States:
  - BOOT: one cycle after reset release, no request.
  - FETCH: issuing a request.
  - WAIT: request accepted, response pending.
  - HOLD: instruction buffered, decode stalled.
  - DRAIN: response pending for a squashed request.
- Default outputs: io_stall_en=1, io_jal_en=0, io_jalr_en=0, io_inst_valid=0.
- BOOT → FETCH unconditionally.
- FETCH:
  - io_imem_req_valid = !io_redirect_valid.
  - On handshake, latch the req PC and go to WAIT.
  - The memory tolerates valid being withdrawn without a handshake.
- WAIT, on io_imem_resp_valid:
  - io_inst_valid=1, io_inst=resp_data, io_inst_pc=latched PC (combinational).
  - If !io_dec_stall: io_stall_en=0 (PC+4), then FETCH.
  - Else: buffer the word, then HOLD.
- HOLD: io_inst_valid=1 from the buffer. When !io_dec_stall: io_stall_en=0, then FETCH.
- DRAIN: any response is discarded (io_inst_valid=0), io_squash_count increments, then FETCH.
- Redirect (io_redirect_valid=1) has the highest priority in every state except BOOT, where it is ignored:
  - io_stall_en=0.
  - io_jalr_en=io_redirect_is_jalr; io_jal_en=!io_redirect_is_jalr.
  - io_inst_valid=0 that cycle.
  - Next state:
    - FETCH → FETCH.
    - HOLD → FETCH; the buffer is dropped.
    - WAIT without a response → DRAIN.
    - WAIT with a response in the same cycle → FETCH; the response is discarded and counted.
    - DRAIN without a response → DRAIN.
    - DRAIN with a response → FETCH; the response is counted.
- io_jal_en and io_jalr_en are never both 1. Neither is asserted while io_stall_en=1.
- io_squash_count saturates at 2^SQ_CNT_W-1.

## Timing
- Reset values:
  - state=BOOT, io_stall_en=1.
  - io_imem_req_valid, io_jal_en, io_jalr_en, io_inst_valid = 0.
  - io_inst, io_inst_pc, io_squash_count = 0.
- Reset asserted mid-operation: immediate return to BOOT. Any outstanding response is lost (memory is reset too).
- Minimum fetch: request in cycle N, response in cycle N+1, instruction to decode in cycle N+1. Peak rate is 1 instruction per 2 cycles.
- PC changes only on an edge where io_stall_en=0: exactly one advance per delivered instruction or redirect.
- After a redirect, the new PC is on io_pc in the next cycle and the request for it is issued no earlier than that cycle.
- io_imm and io_rs1 are combinational with zero latency. All other outputs derive from registered state plus same-cycle inputs.

## Test plan
- Reset release with memory always ready and 1-cycle response: addresses 0x0, 0x4, 0x8 are requested in cycles 1, 3, 5; io_inst_pc matches each address.
- io_dec_stall high for 3 cycles on the instruction at 0x4: io_inst_valid stays 1 with a stable word, io_pc stays at 0x4, then advances to 0x8 the cycle after stall drops.
- jal redirect with imm=0x20 while in WAIT at pc 0x8:
  - io_jal_en=1 for one cycle and the PC becomes 0x28.
  - The late response for 0x8 is discarded and io_squash_count becomes 1.
  - The next request is for 0x28.
- jalr redirect with rs1=0x100, imm=0x4 in the same cycle as a response in WAIT: the response is dropped, the next request is for 0x104, and the FSM does not enter DRAIN.
- Redirect while in FETCH with io_imem_req_ready=1: io_imem_req_valid=0 that cycle, no handshake occurs, and the next request carries the new PC.
- Assert reset low mid-WAIT: all outputs return to their reset values immediately, and the first request after release is for 0x0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Sequencing controller for the fetch unit. It keeps at most one instruction
//   memory request in flight using the current PC. Fetched words go to decode
//   with backpressure. It drives the fetch unit's stall/jal/jalr controls,
//   applies redirects from execute, and discards responses that belong to
//   squashed fetches.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   io_pc                  current PC from the fetch unit
//   io_imem_req_*          request channel to instruction memory (valid/ready/addr)
//   io_imem_resp_*         response strobe and instruction word
//   io_redirect_*          one-cycle redirect from execute (jal or jalr, rs1, imm)
//   io_dec_stall           decode cannot accept an instruction this cycle
//   io_stall_en/jal_en/jalr_en  PC control to the fetch unit
//   io_imm, io_rs1         combinational pass-through of the redirect operands
//   io_inst_valid/inst/inst_pc  instruction handed to decode
//   io_squash_count        saturating count of discarded responses
module fetch_ctrl #(
  parameter int XLEN     = 32,
  parameter int SQ_CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [XLEN-1:0]     io_pc,
  output logic                io_imem_req_valid,
  input  logic                io_imem_req_ready,
  output logic [XLEN-1:0]     io_imem_req_addr,
  input  logic                io_imem_resp_valid,
  input  logic [31:0]         io_imem_resp_data,
  input  logic                io_redirect_valid,
  input  logic                io_redirect_is_jalr,
  input  logic [XLEN-1:0]     io_redirect_rs1,
  input  logic [XLEN-1:0]     io_redirect_imm,
  input  logic                io_dec_stall,
  output logic                io_stall_en,
  output logic                io_jal_en,
  output logic                io_jalr_en,
  output logic [XLEN-1:0]     io_imm,
  output logic [XLEN-1:0]     io_rs1,
  output logic                io_inst_valid,
  output logic [31:0]         io_inst,
  output logic [XLEN-1:0]     io_inst_pc,
  output logic [SQ_CNT_W-1:0] io_squash_count
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [XLEN-1:0]       r_reqPc;
  logic [31:0]           r_instBuf;
  logic [SQ_CNT_W-1:0]   r_squashCnt;

  logic                  w_redirect;
  logic                  w_handshake;
  logic                  w_bufLoad;
  logic                  w_squashInc;

  // The boot cycle ignores redirects entirely.
  assign w_redirect = io_redirect_valid && (r_state != S_BOOT);

  assign io_imem_req_addr = io_pc;
  assign io_imm           = io_redirect_imm;
  assign io_rs1           = io_redirect_rs1;
  // In WAIT the word comes straight from memory. Elsewhere it comes from the
  // buffer; it only matters in HOLD.
  assign io_inst          = (r_state == S_WAIT) ? io_imem_resp_data : r_instBuf;
  assign io_inst_pc       = r_reqPc;
  assign io_squash_count  = r_squashCnt;

  always_comb begin
    w_nextState       = r_state;
    io_imem_req_valid = 1'b0;
    io_stall_en       = 1'b1;
    io_jal_en         = 1'b0;
    io_jalr_en        = 1'b0;
    io_inst_valid     = 1'b0;
    w_handshake       = 1'b0;
    w_bufLoad         = 1'b0;
    w_squashInc       = 1'b0;

    case (r_state)
      S_BOOT: begin
        w_nextState = S_FETCH;
      end

      S_FETCH: begin
        // Withdrawing valid on a redirect keeps the stale PC from being fetched.
        io_imem_req_valid = !io_redirect_valid;
        if (!io_redirect_valid && io_imem_req_ready) begin
          w_handshake = 1'b1;
          w_nextState = S_WAIT;
        end
      end

      S_WAIT: begin
        if (io_imem_resp_valid) begin
          if (w_redirect) begin
            w_squashInc = 1'b1;
            w_nextState = S_FETCH;
          end else begin
            io_inst_valid = 1'b1;
            if (!io_dec_stall) begin
              io_stall_en = 1'b0;
              w_nextState = S_FETCH;
            end else begin
              w_bufLoad   = 1'b1;
              w_nextState = S_HOLD;
            end
          end
        end else if (w_redirect) begin
          w_nextState = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (w_redirect) begin
          w_nextState = S_FETCH;
        end else begin
          io_inst_valid = 1'b1;
          if (!io_dec_stall) begin
            io_stall_en = 1'b0;
            w_nextState = S_FETCH;
          end
        end
      end

      S_DRAIN: begin
        // The response still owed to a squashed request is swallowed here.
        // A further redirect does not matter; only one request is in flight.
        if (io_imem_resp_valid) begin
          w_squashInc = 1'b1;
          w_nextState = S_FETCH;
        end
      end

      default: begin
        w_nextState = S_BOOT;
      end
    endcase

    // A redirect overrides the per-state PC control. The PC advances through
    // jal or jalr, and no instruction is offered to decode.
    if (w_redirect) begin
      io_stall_en   = 1'b0;
      io_jalr_en    = io_redirect_is_jalr;
      io_jal_en     = !io_redirect_is_jalr;
      io_inst_valid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request PC latch, decode hold buffer and saturating squash counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_reqPc     <= '0;
      r_instBuf   <= '0;
      r_squashCnt <= '0;
    end else begin
      if (w_handshake) begin
        r_reqPc <= io_pc;
      end
      if (w_bufLoad) begin
        r_instBuf <= io_imem_resp_data;
      end
      if (w_squashInc && (r_squashCnt != '1)) begin
        r_squashCnt <= r_squashCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. The bench plays the fetch unit's PC register
//   and an instruction memory with a programmable response delay. An abstract
//   model of the fetch pipeline predicts every output each cycle. The model
//   tracks whether a request is outstanding, whether it was squashed, and
//   whether a word is buffered. Literal checks on request/delivery logs and on
//   the model PC pin the scenarios by hand.
module tb_fetch_ctrl;

  localparam int XLEN     = 32;
  localparam int SQ_CNT_W = 16;

  logic                clock;
  logic                reset;
  logic [XLEN-1:0]     io_pc;
  logic                io_imem_req_valid;
  logic                io_imem_req_ready;
  logic [XLEN-1:0]     io_imem_req_addr;
  logic                io_imem_resp_valid;
  logic [31:0]         io_imem_resp_data;
  logic                io_redirect_valid;
  logic                io_redirect_is_jalr;
  logic [XLEN-1:0]     io_redirect_rs1;
  logic [XLEN-1:0]     io_redirect_imm;
  logic                io_dec_stall;
  logic                io_stall_en;
  logic                io_jal_en;
  logic                io_jalr_en;
  logic [XLEN-1:0]     io_imm;
  logic [XLEN-1:0]     io_rs1;
  logic                io_inst_valid;
  logic [31:0]         io_inst;
  logic [XLEN-1:0]     io_inst_pc;
  logic [SQ_CNT_W-1:0] io_squash_count;

  fetch_ctrl #(.XLEN(XLEN), .SQ_CNT_W(SQ_CNT_W)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_pc               (io_pc),
    .io_imem_req_valid   (io_imem_req_valid),
    .io_imem_req_ready   (io_imem_req_ready),
    .io_imem_req_addr    (io_imem_req_addr),
    .io_imem_resp_valid  (io_imem_resp_valid),
    .io_imem_resp_data   (io_imem_resp_data),
    .io_redirect_valid   (io_redirect_valid),
    .io_redirect_is_jalr (io_redirect_is_jalr),
    .io_redirect_rs1     (io_redirect_rs1),
    .io_redirect_imm     (io_redirect_imm),
    .io_dec_stall        (io_dec_stall),
    .io_stall_en         (io_stall_en),
    .io_jal_en           (io_jal_en),
    .io_jalr_en          (io_jalr_en),
    .io_imm              (io_imm),
    .io_rs1              (io_rs1),
    .io_inst_valid       (io_inst_valid),
    .io_inst             (io_inst),
    .io_inst_pc          (io_inst_pc),
    .io_squash_count     (io_squash_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Abstract pipeline model
  bit          mBooted;
  bit          mOutstanding;
  bit          mSquashed;
  bit          mHaveInst;
  logic [31:0] mBufInst;
  logic [31:0] mReqPc;
  logic [31:0] mPc;
  logic [15:0] mCount;

  // Per-cycle expectations
  bit          eRedir, eRespNow, eDeliverResp, eReqValid, eInstValid;
  bit          eStall, eJal, eJalr, eHandshake, eSquashInc;
  logic [31:0] eInst;
  logic [31:0] eInstPc;

  // Memory model
  bit          memPending;
  int          memLeft;
  int          respDelay;
  logic [31:0] memAddr;

  // Observation logs for literal checks
  int          reqCyc[$];
  logic [31:0] reqAddr[$];
  logic [31:0] dlvPc[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Compute what the outputs must be from pipeline occupancy and the inputs.
  task automatic computeModel();
    eRedir       = mBooted && io_redirect_valid;
    eRespNow     = mOutstanding && io_imem_resp_valid;
    eDeliverResp = eRespNow && !mSquashed;
    eReqValid    = mBooted && !mOutstanding && !mHaveInst && !eRedir;
    eInstValid   = !eRedir && (mHaveInst || eDeliverResp);
    eInst        = mHaveInst ? mBufInst : io_imem_resp_data;
    eInstPc      = mReqPc;
    eStall       = !(eRedir || (eInstValid && !io_dec_stall));
    eJal         = eRedir && !io_redirect_is_jalr;
    eJalr        = eRedir && io_redirect_is_jalr;
    eHandshake   = eReqValid && io_imem_req_ready;
    eSquashInc   = eRespNow && (mSquashed || eRedir);
  endtask

  task automatic checkOutput();
    computeModel();
    check("req_valid",    32'(io_imem_req_valid), 32'(eReqValid));
    check("req_addr",     io_imem_req_addr, io_pc);
    check("stall_en",     32'(io_stall_en), 32'(eStall));
    check("jal_en",       32'(io_jal_en), 32'(eJal));
    check("jalr_en",      32'(io_jalr_en), 32'(eJalr));
    check("inst_valid",   32'(io_inst_valid), 32'(eInstValid));
    if (eInstValid) begin
      check("inst",    io_inst, eInst);
      check("inst_pc", io_inst_pc, eInstPc);
    end
    check("squash_count", 32'(io_squash_count), 32'(mCount));
    check("imm_pass",     io_imm, io_redirect_imm);
    check("rs1_pass",     io_rs1, io_redirect_rs1);
    if (io_imem_req_valid && io_imem_req_ready) begin
      reqCyc.push_back(cyc);
      reqAddr.push_back(io_imem_req_addr);
    end
    if (io_inst_valid && !io_dec_stall) begin
      dlvPc.push_back(io_inst_pc);
    end
  endtask

  // Advance the model, the fetch unit PC and the memory across one clock edge.
  task automatic updateModel();
    if (!mBooted) begin
      mBooted = 1'b1;
    end else begin
      if (eRespNow) begin
        mOutstanding = 1'b0;
      end else if (eHandshake) begin
        mOutstanding = 1'b1;
        mSquashed    = 1'b0;
        mReqPc       = io_pc;
      end
      if (eRedir) begin
        mHaveInst = 1'b0;
        if (mOutstanding) mSquashed = 1'b1;
      end else if (eDeliverResp && io_dec_stall) begin
        mHaveInst = 1'b1;
        mBufInst  = io_imem_resp_data;
      end else if (mHaveInst && !io_dec_stall) begin
        mHaveInst = 1'b0;
      end
      if (eSquashInc && (mCount != 16'hFFFF)) mCount++;
      if (!eStall) begin
        if (eJal)       mPc = mPc + io_redirect_imm;
        else if (eJalr) mPc = io_redirect_rs1 + io_redirect_imm;
        else            mPc = mPc + 32'd4;
      end
    end
    if (memPending) begin
      if (memLeft <= 1) memPending = 1'b0;
      else              memLeft--;
    end
    if (eHandshake) begin
      memPending = 1'b1;
      memLeft    = respDelay;
      memAddr    = io_pc;
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, then step the model at the edge.
  task automatic applyStimulus(input bit rv, input bit isJalr, input logic [31:0] rs1,
                               input logic [31:0] imm, input bit decStall, input bit ready);
    io_redirect_valid   = rv;
    io_redirect_is_jalr = isJalr;
    io_redirect_rs1     = rs1;
    io_redirect_imm     = imm;
    io_dec_stall        = decStall;
    io_imem_req_ready   = ready;
    io_pc               = mPc;
    io_imem_resp_valid  = memPending && (memLeft == 1);
    io_imem_resp_data   = io_imem_resp_valid ? memWord(memAddr) : 32'hDEAD_BEEF;
    @(negedge clock);
    #1;
    checkOutput();
    @(posedge clock);
    updateModel();
    cyc++;
    #1;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  // Assert reset asynchronously, check reset values at once, then release.
  task automatic doReset();
    io_redirect_valid   = 1'b0;
    io_redirect_is_jalr = 1'b0;
    io_redirect_rs1     = '0;
    io_redirect_imm     = '0;
    io_dec_stall        = 1'b0;
    io_imem_req_ready   = 1'b1;
    io_imem_resp_valid  = 1'b0;
    io_pc               = '0;
    reset = 1'b0;
    #1;
    check("rst_req_valid",  32'(io_imem_req_valid), 32'd0);
    check("rst_stall_en",   32'(io_stall_en), 32'd1);
    check("rst_jal_en",     32'(io_jal_en), 32'd0);
    check("rst_jalr_en",    32'(io_jalr_en), 32'd0);
    check("rst_inst_valid", 32'(io_inst_valid), 32'd0);
    check("rst_inst",       io_inst, 32'd0);
    check("rst_inst_pc",    io_inst_pc, 32'd0);
    check("rst_squash",     32'(io_squash_count), 32'd0);
    mBooted = 0; mOutstanding = 0; mSquashed = 0; mHaveInst = 0;
    mBufInst = '0; mReqPc = '0; mPc = '0; mCount = '0;
    memPending = 0; memLeft = 0; memAddr = '0; respDelay = 1;
    reqCyc.delete(); reqAddr.delete(); dlvPc.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic checkReq(input int idx, input int eCyc, input logic [31:0] eAddr);
    if (idx < reqCyc.size()) begin
      check($sformatf("req%0d_cycle", idx), 32'(reqCyc[idx]), 32'(eCyc));
      check($sformatf("req%0d_addr", idx), reqAddr[idx], eAddr);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL req%0d_missing: got %0d requests want more than %0d", idx, reqCyc.size(), idx);
    end
  endtask

  task automatic checkDlv(input int idx, input logic [31:0] ePc);
    if (idx < dlvPc.size()) begin
      check($sformatf("dlv%0d_pc", idx), dlvPc[idx], ePc);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL dlv%0d_missing: got %0d deliveries want more than %0d", idx, dlvPc.size(), idx);
    end
  endtask

  initial begin
    reset = 1'b1;
    #2;
    doReset();

    // Back-to-back fetches, then a jal redirect while the 0x8 response is late
    plain(5);                                            // c0..c4
    respDelay = 3;
    plain(1);                                            // c5 request 0x8
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h20, 1'b0, 1'b1);  // c6 WAIT jal +0x20
    check("pc_after_jal", mPc, 32'h28);
    plain(2);                                            // c7,c8 drain
    check("squash_after_jal", 32'(io_squash_count), 32'd1);
    respDelay = 1;
    plain(1);                                            // c9 request 0x28
    applyStimulus(1'b1, 1'b1, 32'h100, 32'h4, 1'b0, 1'b1); // c10 jalr with response
    check("squash_after_jalr", 32'(io_squash_count), 32'd2);
    check("pc_after_jalr", mPc, 32'h104);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h10, 1'b0, 1'b1);  // c11 redirect in FETCH
    respDelay = 5;
    plain(2);                                            // c12 request 0x114, c13 WAIT
    checkReq(0, 1, 32'h0);
    checkReq(1, 3, 32'h4);
    checkReq(2, 5, 32'h8);
    checkReq(3, 9, 32'h28);
    checkReq(4, 12, 32'h114);
    check("reqs_run_a", 32'(reqCyc.size()), 32'd5);
    checkDlv(0, 32'h0);
    checkDlv(1, 32'h4);
    check("dlv_run_a", 32'(dlvPc.size()), 32'd2);

    // Reset in the middle of WAIT
    doReset();

    // Redirect during boot is ignored, then decode backpressure and a HOLD redirect
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h40, 1'b0, 1'b1);  // c0 BOOT
    check("pc_boot_redirect", mPc, 32'h0);
    plain(3);                                            // c1..c3
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);   // c4 response 0x4, stalled
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);   // c5 HOLD
    check("hold_word", io_inst, 32'hC0DE_0004);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);   // c6 HOLD
    check("pc_held", mPc, 32'h4);
    plain(1);                                            // c7 delivered from HOLD
    check("pc_after_hold", mPc, 32'h8);
    plain(1);                                            // c8 request 0x8
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);   // c9 response, stalled
    applyStimulus(1'b1, 1'b1, 32'h200, 32'h0, 1'b1, 1'b1); // c10 jalr from HOLD
    plain(4);                                            // c11..c14
    checkReq(0, 1, 32'h0);
    checkReq(1, 3, 32'h4);
    checkReq(2, 8, 32'h8);
    checkReq(3, 11, 32'h200);
    checkReq(4, 13, 32'h204);
    checkDlv(0, 32'h0);
    checkDlv(1, 32'h4);
    checkDlv(2, 32'h200);
    checkDlv(3, 32'h204);
    check("dlv_run_b", 32'(dlvPc.size()), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
